div_unit: RTL and testbench
===========================

Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider in the EX stage.
- Serves the ALU_SIGNED_DIV and ALU_UNSIGNED_DIV operations selected by the ALU control decode.
- Takes the rs/rt operands, iterates one quotient bit per cycle, then returns the quotient (LO) and remainder (HI) for the HI/LO write.
- Drives a stall request that freezes the pipeline while a divide is in flight. An exception/flush cancels the operation.

Parameters:
- DATA_W, 32, operand/result width; iteration count equals DATA_W.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  divide request; sampled only in IDLE.
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); latched with start.
- opdata_a  in  DATA_W  dividend (rs); latched with start.
- opdata_b  in  DATA_W  divisor (rt); latched with start.
- flush  in  1  cancel the current operation (exception/ERET flush).
- div_stall  out  1  pipeline stall request.
- done  out  1  one-cycle pulse; result valid this cycle.
- quotient  out  DATA_W  LO value; valid when done=1.
- remainder  out  DATA_W  HI value; valid when done=1.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous, active-high. No other clock or reset.
- Reset: state=IDLE, counter=0, done=0, quotient=0, remainder=0. div_stall then follows its equation, so it is 0 unless start=1.
- States: IDLE, ZERO, ON, DONE.
- IDLE:
  - If start=1 and flush=0: latch signed_div, a, b and the result signs.
  - If b==0, go to ZERO. Otherwise load |a| and |b|, set counter=0, go to ON.
  - |x| is the two's-complement negate when signed_div=1 and x[DATA_W-1]=1; otherwise x unchanged.
- ZERO: next cycle DONE with quotient=all ones, remainder=opdata_a as latched.
- ON, one iteration per cycle:
  - Shift the partial remainder left, bringing in the next dividend MSB.
  - Trial subtract the divisor. If non-negative, keep the difference and set the quotient bit to 1; else restore and set it to 0.
  - Counter increments each cycle. After DATA_W iterations (counter reaches DATA_W-1 in the last ON cycle), go to DONE.
- DONE: done=1 for exactly one cycle, with quotient/remainder sign-corrected.
  - Negate the quotient if signed_div and sign(a)!=sign(b).
  - Negate the remainder if signed_div and sign(a)=1.
  - Next state is IDLE unconditionally. start sampled in DONE is ignored, so no re-launch in that cycle.
- Latency: start in cycle T → done in cycle T+DATA_W+1 (T+33 for DATA_W=32). Divide by zero → done at T+2.
- Stall equation: div_stall = (state==IDLE & start & ~flush) | state==ON | state==ZERO. It is 0 in DONE, so the pipeline advances in the done cycle and the HI/LO write happens then.
- Held operands: opdata_a/opdata_b/signed_div may change after the start cycle without effect.
- Flush:
  - flush=1 in any state → next state IDLE, counter=0, no done pulse. flush beats start.
  - flush in DONE: done is still asserted this cycle. The consumer gates the HI/LO write with its own flush.
- rst overrides flush and start. Reset mid-ON → IDLE next cycle, done=0.
- Overflow: signed 0x80000000 / 0xFFFFFFFF → quotient 0x80000000, remainder 0 (natural wrap, no trap).
- Outputs hold their last values outside DONE. Consumers use them only when done=1.

Test Plan:
- Unsigned: start, signed_div=0, a=100, b=7 → div_stall high for cycles T..T+32, done at T+33, quotient=14, remainder=2.
- Signed: a=0xFFFFFFF9 (-7), b=2 → quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1). Also a=7, b=0xFFFFFFFE → quotient=0xFFFFFFFD, remainder=1. Also a=0xFFFFFFF9 as unsigned, b=2 → quotient=0x7FFFFFFC, remainder=1.
- Divide by zero: a=0x12345678, b=0 → done at T+2, quotient=0xFFFFFFFF, remainder=0x12345678. Signed overflow 0x80000000/0xFFFFFFFF → quotient=0x80000000, remainder=0.
- Flush at T+10 → IDLE at T+11, div_stall=0, no done pulse.
  - New start at T+12 (a=9, b=3) → done at T+45, quotient=3, remainder=0.
- rst asserted mid-ON → all outputs 0 next cycle, no done pulse.
- Operand changes after T are ignored. Back-to-back: start held high through DONE → second operation launches from IDLE, one cycle after done.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU: one quotient bit per cycle,
// with a stall request to hold the pipeline while a divide is in flight.
module div_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_div,
  input  logic [DATA_W-1:0] opdata_a,
  input  logic [DATA_W-1:0] opdata_b,
  input  logic              flush,
  output logic              div_stall,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int CW = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, ZERO, ON, DONE} state_t;
  state_t state, state_nxt;

  logic [CW-1:0]     cnt;
  logic [DATA_W-1:0] dvd;    // dividend bits shift out, quotient bits shift in
  logic [DATA_W-1:0] dvs;
  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] a_raw;
  logic              neg_q, neg_r;

  logic [DATA_W:0]   trial;
  logic              q_bit;
  logic [DATA_W-1:0] rem_nxt, q_nxt;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic s);
    return (s && x[DATA_W-1]) ? -x : x;
  endfunction

  // Partial remainder is always < divisor, so the shifted value fits in DATA_W+1 bits.
  always_comb begin
    trial   = {rem, dvd[DATA_W-1]} - {1'b0, dvs};
    q_bit   = ~trial[DATA_W];
    rem_nxt = q_bit ? trial[DATA_W-1:0] : {rem[DATA_W-2:0], dvd[DATA_W-1]};
    q_nxt   = {dvd[DATA_W-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    div_stall = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start && !flush) begin
        div_stall = 1'b1;
        state_nxt = (opdata_b == '0) ? ZERO : ON;
      end
      ZERO: begin
        div_stall = 1'b1;
        state_nxt = DONE;
      end
      ON: begin
        div_stall = 1'b1;
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Results are written only on the transition into DONE and held otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      a_raw     <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_raw <= opdata_a;
          neg_q <= signed_div & (opdata_a[DATA_W-1] ^ opdata_b[DATA_W-1]);
          neg_r <= signed_div & opdata_a[DATA_W-1];
          dvd   <= mag(opdata_a, signed_div);
          dvs   <= mag(opdata_b, signed_div);
          rem   <= '0;
          cnt   <= '0;
        end
        ZERO: begin
          quotient  <= '1;
          remainder <= a_raw;
        end
        ON: begin
          cnt <= cnt + 1'b1;
          dvd <= q_nxt;
          rem <= rem_nxt;
          if (cnt == LAST) begin
            quotient  <= neg_q ? -q_nxt : q_nxt;
            remainder <= neg_r ? -rem_nxt : rem_nxt;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: directed spec cases plus randomized traffic, all checked
// every cycle against a timeline model built on plain integer division.
module tb_div_unit;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst, start, signed_div, flush;
  logic [W-1:0] opdata_a, opdata_b;
  logic         div_stall, done;
  logic [W-1:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  div_unit #(.DATA_W(W)) dut (
    .clk(clk), .rst(rst), .start(start), .signed_div(signed_div),
    .opdata_a(opdata_a), .opdata_b(opdata_b), .flush(flush),
    .div_stall(div_stall), .done(done), .quotient(quotient), .remainder(remainder)
  );

  task automatic check(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference result from ordinary truncating division.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                                  output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = 32'(sa / sb);
      r  = 32'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Timeline model: after a launch the unit is busy for m_left cycles, done when it hits 0.
  bit           m_valid = 0, m_busy = 0;
  int           m_left  = 0;
  logic [W-1:0] m_q = '0, m_r = '0, p_q = '0, p_r = '0;

  always @(negedge clk) begin
    if (m_valid) begin
      check1("done", done, m_busy && m_left == 0);
      check1("div_stall", div_stall, m_busy ? (m_left != 0) : (start && !flush));
      check("quotient", quotient, m_q);
      check("remainder", remainder, m_r);
    end
    if (rst) begin
      m_valid = 1; m_busy = 0; m_q = '0; m_r = '0;
    end else if (flush) begin
      m_busy = 0;
    end else if (m_busy) begin
      if (m_left == 0) m_busy = 0;
      else begin
        m_left--;
        if (m_left == 0) begin m_q = p_q; m_r = p_r; end
      end
    end else if (start) begin
      m_busy = 1;
      m_left = (opdata_b == 0) ? 1 : W;
      ref_div(opdata_a, opdata_b, signed_div, p_q, p_r);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit s,
                        input logic [W-1:0] eq, input logic [W-1:0] er, input int lat, input string nm);
    int n;
    start = 1; opdata_a = a; opdata_b = b; signed_div = s;
    tick();
    start = 0; opdata_a = $urandom; opdata_b = $urandom; signed_div = 1'($urandom);
    n = 1;
    @(negedge clk);
    while (!done && n < 60) begin @(negedge clk); n++; end
    check({nm, "_latency"}, n, lat);
    check({nm, "_q"}, quotient, eq);
    check({nm, "_r"}, remainder, er);
    tick();
  endtask

  logic [W-1:0] tq, tr;

  initial begin
    int m;
    rst = 1; start = 0; flush = 0; signed_div = 0; opdata_a = '0; opdata_b = '0;

    // Pin the model against hand-computed values.
    ref_div(100, 7, 0, tq, tr);                       check("ref_u_q", tq, 14);           check("ref_u_r", tr, 2);
    ref_div(32'hFFFFFFF9, 2, 1, tq, tr);              check("ref_s1_q", tq, 32'hFFFFFFFD); check("ref_s1_r", tr, 32'hFFFFFFFF);
    ref_div(7, 32'hFFFFFFFE, 1, tq, tr);              check("ref_s2_q", tq, 32'hFFFFFFFD); check("ref_s2_r", tr, 1);
    ref_div(32'hFFFFFFF9, 2, 0, tq, tr);              check("ref_u2_q", tq, 32'h7FFFFFFC); check("ref_u2_r", tr, 1);
    ref_div(32'h80000000, 32'hFFFFFFFF, 1, tq, tr);   check("ref_ov_q", tq, 32'h80000000); check("ref_ov_r", tr, 0);
    ref_div(32'h12345678, 0, 1, tq, tr);              check("ref_z_q", tq, 32'hFFFFFFFF);  check("ref_z_r", tr, 32'h12345678);

    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    check1("rst_done", done, 1'b0);
    check1("rst_stall", div_stall, 1'b0);
    check("rst_q", quotient, '0);
    check("rst_r", remainder, '0);
    tick();

    run_op(100, 7, 0, 14, 2, 33, "udiv");
    run_op(32'hFFFFFFF9, 2, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, "sdiv_neg_a");
    run_op(7, 32'hFFFFFFFE, 1, 32'hFFFFFFFD, 1, 33, "sdiv_neg_b");
    run_op(32'hFFFFFFF9, 2, 0, 32'h7FFFFFFC, 1, 33, "udiv_big");
    run_op(32'h12345678, 0, 1, 32'hFFFFFFFF, 32'h12345678, 2, "div0");
    run_op(32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000, 0, 33, "sovf");

    // Flush mid-divide, then relaunch.
    start = 1; opdata_a = 1000; opdata_b = 3; signed_div = 0;
    tick();
    start = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    @(negedge clk);
    check1("flush_stall", div_stall, 1'b0);
    check1("flush_done", done, 1'b0);
    tick();
    run_op(9, 3, 0, 3, 0, 33, "post_flush");

    // Reset mid-divide clears everything.
    start = 1; opdata_a = 77; opdata_b = 5;
    tick();
    start = 0;
    repeat (5) tick();
    rst = 1;
    tick();
    rst = 0;
    @(negedge clk);
    check("midrst_q", quotient, '0);
    check("midrst_r", remainder, '0);
    check1("midrst_done", done, 1'b0);
    check1("midrst_stall", div_stall, 1'b0);
    tick();

    // Start held high through DONE: second launch comes from IDLE one cycle later.
    start = 1; opdata_a = 50; opdata_b = 5; signed_div = 0;
    tick();
    m = 1;
    @(negedge clk);
    while (!done && m < 60) begin @(negedge clk); m++; end
    check("b2b_lat1", m, 33);
    tick();
    m = 1;
    @(negedge clk);
    while (!done && m < 60) begin @(negedge clk); m++; end
    check("b2b_lat2", m, 34);
    check("b2b_q", quotient, 10);
    check("b2b_r", remainder, 0);
    start = 0;
    tick();

    // Random traffic: frequent starts, occasional flush and reset.
    repeat (3000) begin
      start      = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 99) < 3);
      rst        = ($urandom_range(0, 499) == 0);
      signed_div = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       opdata_a = 32'h80000000;
        1:       opdata_a = $urandom_range(0, 255);
        default: opdata_a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0:       opdata_b = '0;
        1:       opdata_b = $urandom_range(1, 15);
        2:       opdata_b = 32'hFFFFFFFF;
        default: opdata_b = $urandom;
      endcase
      tick();
    end
    start = 0; flush = 0; rst = 0;
    repeat (40) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
